pg_pipe_buffer: RTL and testbench

Parametrised, elastic pipeline buffer for propagate/generate vectors between prefix-tree levels of the adder family. It generalises the single-bit P/G delay buffer to a WIDTH-bit P/G bus plus carry-in, and to STAGES registered, back-pressure-aware pipeline stages with a valid/ready handshake. It sits between any two prefix levels (or between the PG generator and the tree) so that deep adders can be pipelined and stalled without losing or duplicating operands.

---
 rtl/pg_pkg.sv | 18 +
 rtl/pg_skid_stage.sv | 92 +++++++++
 rtl/pg_pipe_buffer.sv | 79 +++++++
 tb/tb_pg_pipe_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pg_pkg.sv
// Shared types and elaboration helpers for the elastic P/G pipeline buffer.
package pg_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   function automatic int pg_occ_width(input int stages);
      return $clog2(2*stages + 1);
   endfunction

   function automatic bit pg_params_ok(input int width, input int stages);
      return (width >= 1) && (stages >= 1);
   endfunction

endpackage

// File: rtl/pg_skid_stage.sv
// One 2-entry skid stage carrying a packed {p, g, cin} word with a valid/ready handshake.
//
//  state | meaning
//  EMPTY | nothing held; ready, not valid
//  BUSY  | main holds the head word; ready and valid
//  FULL  | main and skid both hold words; valid, not ready
module pg_skid_stage
   import pg_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*WIDTH:0] in_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*WIDTH:0] out_word
);

   localparam int DW = 2*WIDTH + 1;

   stage_state_t  state_q;
   stage_state_t  state_d;
   logic [DW-1:0] main_q;
   logic [DW-1:0] skid_q;
   logic          accept;
   logic          drain;
   logic          load_main_in;
   logic          load_main_skid;
   logic          load_skid;

   // Handshake outputs come from the state register only, so out_ready never reaches in_ready.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_word  = main_q;
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d      = BUSY;
               load_main_in = 1'b1;
            end
         end
         BUSY: begin
            if (accept && drain) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               state_d        = BUSY;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_main_in) begin
            main_q <= in_word;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_word;
         end
      end
   end

endmodule

// File: rtl/pg_pipe_buffer.sv
// Elastic pipeline buffer for WIDTH-bit P/G buses plus carry-in: a chain of
// STAGES skid stages with a registered occupancy counter.
module pg_pipe_buffer
   import pg_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
)
(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WIDTH-1:0]                  in_p,
   input  logic [WIDTH-1:0]                  in_g,
   input  logic                              in_cin,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [WIDTH-1:0]                  out_p,
   output logic [WIDTH-1:0]                  out_g,
   output logic                              out_cin,
   output logic [pg_occ_width(STAGES)-1:0]   occupancy
);

   localparam int            DW      = 2*WIDTH + 1;
   localparam int            OW      = pg_occ_width(STAGES);
   localparam logic [OW-1:0] OCC_MAX = OW'(2*STAGES);

   if (!pg_params_ok(WIDTH, STAGES)) begin : g_param_err
      $error("pg_pipe_buffer: WIDTH and STAGES must both be at least 1");
   end

   logic [DW-1:0] chain_word  [STAGES+1];
   logic          chain_valid [STAGES+1];
   logic          chain_ready [STAGES+1];
   logic [OW-1:0] occ_q;
   logic          up;
   logic          dn;

   assign chain_word[0]       = {in_p, in_g, in_cin};
   assign chain_valid[0]      = in_valid;
   assign chain_ready[STAGES] = out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pg_skid_stage #(.WIDTH(WIDTH)) u_stage (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (chain_valid[k]),
         .in_ready  (chain_ready[k]),
         .in_word   (chain_word[k]),
         .out_valid (chain_valid[k+1]),
         .out_ready (chain_ready[k+1]),
         .out_word  (chain_word[k+1])
      );
   end

   assign in_ready  = chain_ready[0];
   assign out_valid = chain_valid[STAGES];
   assign out_p     = chain_word[STAGES][DW-1 -: WIDTH];
   assign out_g     = chain_word[STAGES][WIDTH:1];
   assign out_cin   = chain_word[STAGES][0];

   assign up = in_valid & chain_ready[0];
   assign dn = chain_valid[STAGES] & out_ready;

   // Clamps are belt-and-braces; the handshakes already bound the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else if (up && !dn && (occ_q != OCC_MAX)) begin
         occ_q <= occ_q + OW'(1);
      end else if (dn && !up && (occ_q != '0)) begin
         occ_q <= occ_q - OW'(1);
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_pg_pipe_buffer.sv
// Directed and scoreboard bench for pg_pipe_buffer: default config plus STAGES=1/WIDTH=1.
module tb_pg_pipe_buffer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        a_iv = 1'b0, a_or = 1'b0, a_cin = 1'b0;
   logic [15:0] a_p = '0, a_g = '0;
   logic        a_ir, a_ov, a_ocin;
   logic [15:0] a_op, a_og;
   logic [2:0]  a_occ;

   logic        b_iv = 1'b0, b_or = 1'b0, b_cin = 1'b0;
   logic [0:0]  b_p = '0, b_g = '0;
   logic        b_ir, b_ov, b_ocin;
   logic [0:0]  b_op, b_og;
   logic [1:0]  b_occ;

   pg_pipe_buffer #(.WIDTH(16), .STAGES(2)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_iv), .in_ready(a_ir), .in_p(a_p), .in_g(a_g), .in_cin(a_cin),
      .out_valid(a_ov), .out_ready(a_or), .out_p(a_op), .out_g(a_og), .out_cin(a_ocin),
      .occupancy(a_occ)
   );

   pg_pipe_buffer #(.WIDTH(1), .STAGES(1)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_iv), .in_ready(b_ir), .in_p(b_p), .in_g(b_g), .in_cin(b_cin),
      .out_valid(b_ov), .out_ready(b_or), .out_p(b_op), .out_g(b_og), .out_cin(b_ocin),
      .occupancy(b_occ)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic        iv;
      logic        orr;
      logic [15:0] p;
      logic [15:0] g;
      logic        cin;
      logic        e_ir;
      logic        e_ov;
      logic [2:0]  e_occ;
      logic [15:0] e_p;
      logic [15:0] e_g;
      logic        e_cin;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic orr, input logic [15:0] p,
                               input logic [15:0] g, input logic cin, input logic e_ir,
                               input logic e_ov, input logic [2:0] e_occ,
                               input logic [15:0] e_p, input logic [15:0] e_g,
                               input logic e_cin);
      vec_t v;
      v.iv = iv; v.orr = orr; v.p = p; v.g = g; v.cin = cin;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ;
      v.e_p = e_p; v.e_g = e_g; v.e_cin = e_cin;
      return v;
   endfunction

   vec_t        tbl [13];
   logic [32:0] sb [$];
   logic [32:0] exp_w;

   initial begin
      // single word, then fill-to-stall, then drain in order
      tbl[0]  = mk(1, 1, 16'hA5A5, 16'h0F0F, 1, 1, 0, 1, 16'h0000, 16'h0000, 0);
      tbl[1]  = mk(0, 1, 16'h0000, 16'h0000, 0, 1, 1, 1, 16'hA5A5, 16'h0F0F, 1);
      tbl[2]  = mk(0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0);
      tbl[3]  = mk(1, 0, 16'h0001, 16'hFFFE, 1, 1, 0, 1, 16'h0000, 16'h0000, 0);
      tbl[4]  = mk(1, 0, 16'h0002, 16'hFFFD, 0, 1, 1, 2, 16'h0001, 16'hFFFE, 1);
      tbl[5]  = mk(1, 0, 16'h0003, 16'hFFFC, 1, 1, 1, 3, 16'h0001, 16'hFFFE, 1);
      tbl[6]  = mk(1, 0, 16'h0004, 16'hFFFB, 0, 0, 1, 4, 16'h0001, 16'hFFFE, 1);
      tbl[7]  = mk(1, 0, 16'h0005, 16'hFFFA, 1, 0, 1, 4, 16'h0001, 16'hFFFE, 1);
      tbl[8]  = mk(1, 0, 16'h0005, 16'hFFFA, 1, 0, 1, 4, 16'h0001, 16'hFFFE, 1);
      tbl[9]  = mk(0, 1, 16'h0000, 16'h0000, 0, 0, 1, 3, 16'h0002, 16'hFFFD, 0);
      tbl[10] = mk(0, 1, 16'h0000, 16'h0000, 0, 1, 1, 2, 16'h0003, 16'hFFFC, 1);
      tbl[11] = mk(0, 1, 16'h0000, 16'h0000, 0, 1, 1, 1, 16'h0004, 16'hFFFB, 0);
      tbl[12] = mk(0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0);

      // reset state, asynchronous, before any clock edge
      #2;
      check("rst_a_ov",  a_ov,  0);
      check("rst_a_ir",  a_ir,  1);
      check("rst_a_occ", a_occ, 0);
      check("rst_a_data", {a_op, a_og, a_ocin}, 0);
      check("rst_b_ov",  b_ov,  0);
      check("rst_b_ir",  b_ir,  1);
      check("rst_b_occ", b_occ, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         a_iv = tbl[i].iv; a_or = tbl[i].orr;
         a_p = tbl[i].p; a_g = tbl[i].g; a_cin = tbl[i].cin;
         @(posedge clk); #1;
         check($sformatf("tbl%0d_ir", i),  a_ir,  tbl[i].e_ir);
         check($sformatf("tbl%0d_ov", i),  a_ov,  tbl[i].e_ov);
         check($sformatf("tbl%0d_occ", i), a_occ, tbl[i].e_occ);
         if (tbl[i].e_ov)
            check($sformatf("tbl%0d_data", i), {a_op, a_og, a_ocin},
                  {tbl[i].e_p, tbl[i].e_g, tbl[i].e_cin});
         @(negedge clk);
      end

      // streaming: 32 words back to back, one out per cycle after a 1-edge head start
      a_or = 1'b1;
      for (int i = 0; i <= 32; i++) begin
         a_iv = (i < 32); a_p = 16'(i); a_g = ~16'(i); a_cin = 1'b0;
         @(posedge clk); #1;
         check($sformatf("stream%0d_ir", i), a_ir, 1);
         if (i >= 1) begin
            check($sformatf("stream%0d_ov", i), a_ov, 1);
            check($sformatf("stream%0d_p", i), {a_op, a_og}, {16'(i-1), ~16'(i-1)});
         end
         @(negedge clk);
      end
      a_iv = 1'b0;
      @(posedge clk); #1;
      check("stream_end_occ", a_occ, 0);
      check("stream_end_ov",  a_ov,  0);

      // random handshakes against a queue scoreboard
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         a_iv = 1'($urandom_range(0, 1)); a_or = 1'($urandom_range(0, 1));
         a_p = 16'($urandom); a_g = 16'($urandom); a_cin = 1'($urandom_range(0, 1));
         #1;
         if (a_ov && a_or) begin
            if (sb.size() == 0) check("rand_underflow", 1, 0);
            else begin
               exp_w = sb.pop_front();
               check("rand_data", {a_op, a_og, a_ocin}, exp_w);
            end
         end
         if (a_iv && a_ir) sb.push_back({a_p, a_g, a_cin});
         @(posedge clk); #1;
         check("rand_occ", a_occ, sb.size());
      end
      @(negedge clk);
      a_iv = 1'b0; a_or = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (a_ov) begin
            if (sb.size() == 0) check("rand_drain_underflow", 1, 0);
            else begin
               exp_w = sb.pop_front();
               check("rand_drain_data", {a_op, a_og, a_ocin}, exp_w);
            end
         end
         @(negedge clk);
      end
      check("rand_drain_left", sb.size(), 0);
      check("rand_drain_occ", a_occ, 0);

      // reset with three words held
      a_or = 1'b0; a_iv = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_p = 16'h0100 + 16'(i); a_g = 16'h0; a_cin = 1'b1;
         @(negedge clk);
      end
      a_iv = 1'b0;
      check("pre_rst_occ", a_occ, 3);
      rst = 1'b1;
      #1;
      check("mid_rst_ov",   a_ov,  0);
      check("mid_rst_occ",  a_occ, 0);
      check("mid_rst_ir",   a_ir,  1);
      check("mid_rst_data", {a_op, a_og, a_ocin}, 0);
      @(negedge clk);
      rst = 1'b0;
      a_iv = 1'b1; a_or = 1'b1; a_p = 16'h1234; a_g = 16'h4321; a_cin = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ov_early", a_ov, 0);
      check("post_rst_occ", a_occ, 1);
      @(negedge clk);
      a_iv = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ov", a_ov, 1);
      check("post_rst_data", {a_op, a_og, a_ocin}, {16'h1234, 16'h4321, 1'b0});
      @(posedge clk); #1;
      check("post_rst_occ_end", a_occ, 0);

      // STAGES=1, WIDTH=1: latency 1, holds two words
      @(negedge clk);
      b_iv = 1'b1; b_or = 1'b0; b_p = 1'b1; b_g = 1'b0; b_cin = 1'b1;
      @(posedge clk); #1;
      check("b_lat_ov", b_ov, 1);
      check("b_lat_data", {b_op, b_og, b_ocin}, 3'b101);
      check("b_occ1", b_occ, 1);
      @(negedge clk);
      b_p = 1'b0; b_g = 1'b1; b_cin = 1'b0;
      @(posedge clk); #1;
      check("b_full_ir", b_ir, 0);
      check("b_occ2", b_occ, 2);
      check("b_hold_data", {b_op, b_og, b_ocin}, 3'b101);
      @(posedge clk); #1;
      check("b_stall_occ", b_occ, 2);
      @(negedge clk);
      b_iv = 1'b0; b_or = 1'b1;
      @(posedge clk); #1;
      check("b_drain_ir", b_ir, 1);
      check("b_drain_occ", b_occ, 1);
      check("b_drain_data", {b_op, b_og, b_ocin}, 3'b010);
      @(posedge clk); #1;
      check("b_empty_ov", b_ov, 0);
      check("b_empty_occ", b_occ, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
